// File: rtl/sipo_frame_pkg.sv
// Shared types and parameter checks for the SIPO frame controller.
package sipo_frame_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned WIDTH_MIN = 2;
  localparam int unsigned WIDTH_MAX = 32;

  function automatic bit width_ok(input int unsigned w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

endpackage

// File: rtl/shift_reg_en.sv
// WIDTH-bit left shift register; serial bit enters at the LSB, clear wins over shift.
module shift_reg_en
  import sipo_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("shift_reg_en: WIDTH out of range");
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// Frame controller: captures WIDTH serial bits after start, holds the word for a valid/ready drain.
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sin,
  input  logic             sin_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("sipo_frame_ctrl: WIDTH out of range");
  end

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             shift_en;
  logic             done;
  logic             hold_free;
  logic             load;
  logic             drop;
  logic             out_valid_n;
  logic             overrun_n;

  shift_reg_en #(.WIDTH(WIDTH)) u_shreg (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .en    (shift_en),
    .din   (sin),
    .q     (shreg)
  );

  // start clears the shifter in either state, so it only gates the shift enable here.
  always_comb begin
    shift_en    = (state == SHIFT) && !start && sin_valid;
    done        = shift_en && (cnt == CNT_LAST);
    word        = {shreg[WIDTH-2:0], sin};
    hold_free   = !out_valid || out_ready;
    load        = done && hold_free;
    drop        = done && !hold_free;

    out_valid_n = out_valid;
    if (load) begin
      out_valid_n = 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid_n = 1'b0;
    end

    overrun_n = overrun;
    if (drop) begin
      overrun_n = 1'b1;
    end else if (clr_overrun) begin
      overrun_n = 1'b0;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SHIFT;
          cnt_n   = '0;
        end
      end
      SHIFT: begin
        if (start) begin
          cnt_n = '0;
        end else if (done) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (shift_en) begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (load) begin
        out_data <= word;
      end
      out_valid <= out_valid_n;
      overrun   <= overrun_n;
    end
  end

  assign busy = (state == SHIFT);

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Directed and randomized checks of sipo_frame_ctrl against a queue-based frame model.
module tb_sipo_frame_ctrl;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         sin;
  logic         sin_valid;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         overrun;
  logic         clr_overrun;

  int errors = 0;
  int checks = 0;

  // Model state: bits collected so far, plus the holding register and flag.
  bit           m_busy;
  bit           m_bits[$];
  bit           m_valid;
  logic [W-1:0] m_data;
  bit           m_over;

  sipo_frame_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sin         (sin),
    .sin_valid   (sin_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic m_reset();
    m_busy  = 0;
    m_bits.delete();
    m_valid = 0;
    m_data  = '0;
    m_over  = 0;
  endtask

  task automatic m_clock();
    bit           done = 0;
    int unsigned  word = 0;
    bit           free;
    if (start) begin
      m_busy = 1;
      m_bits.delete();
    end else if (m_busy && sin_valid) begin
      m_bits.push_back(sin);
      if (m_bits.size() == W) begin
        foreach (m_bits[i]) word = word * 2 + m_bits[i];
        m_bits.delete();
        m_busy = 0;
        done   = 1;
      end
    end
    free = !m_valid || out_ready;
    if (done && !free) m_over = 1;
    else if (clr_overrun) m_over = 0;
    if (done && free) begin
      m_data  = W'(word);
      m_valid = 1;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic idle_inputs();
    start       = 0;
    sin         = 0;
    sin_valid   = 0;
    clr_overrun = 0;
  endtask

  // Start pulse, then W bits MSB first, with gap_len idle cycles after bit index gap_after.
  task automatic send_frame(input logic [W-1:0] w, input int gap_after, input int gap_len);
    logic [W-1:0] v;
    v = w;
    start = 1; step(); start = 0;
    for (int i = 0; i < int'(W); i++) begin
      sin = v[W-1-i]; sin_valid = 1; step();
      sin_valid = 0;
      if (i == gap_after) for (int g = 0; g < gap_len; g++) step();
    end
    sin = 0;
  endtask

  task automatic test_reset();
    reset = 0; out_ready = 0; idle_inputs(); m_reset();
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got=%b exp=0000", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1; reset = 1;
    step();
  endtask

  task automatic test_basic();
    out_ready = 0;
    start = 1; step(); start = 0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_after_start got=%b exp=1", busy); end
    sin = 1; sin_valid = 1; step();
    sin = 0; step();
    sin = 1; step();
    sin = 1; step();
    sin_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got=%b exp=1", out_valid); end
    checks++; if (out_data !== 4'b1011) begin errors++; $display("FAIL basic_out_data got=%b exp=1011", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got=%b exp=0", busy); end
    step();
    checks++; if (out_data !== 4'b1011 || out_valid !== 1'b1) begin errors++; $display("FAIL basic_hold got=%b/%b exp=1011/1", out_data, out_valid); end
    out_ready = 1; step(); out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_gapped();
    out_ready = 0;
    send_frame(4'b1011, 1, 3);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b1011) begin errors++; $display("FAIL gapped_word got=%b/%b exp=1011/1", out_data, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL gapped_busy got=%b exp=0", busy); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_restart();
    out_ready = 0;
    start = 1; step(); start = 0;
    sin = 1; sin_valid = 1; step(); step(); sin_valid = 0;
    send_frame(4'b0010, -1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0010) begin errors++; $display("FAIL restart_word got=%b/%b exp=0010/1", out_data, out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got=%b exp=0", overrun); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_overrun();
    out_ready = 0;
    send_frame(4'b1100, -1, 0);
    send_frame(4'b0011, -1, 0);
    checks++; if (out_data !== 4'b1100) begin errors++; $display("FAIL overrun_data got=%b exp=1100", out_data); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    out_ready = 1; step(); out_ready = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain got=%b exp=0", out_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    clr_overrun = 1; step(); clr_overrun = 0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_same_cycle_drain();
    logic [W-1:0] v;
    out_ready = 0;
    send_frame(4'b1001, -1, 0);
    v = 4'b0110;
    start = 1; step(); start = 0;
    for (int i = 0; i < int'(W); i++) begin
      sin = v[W-1-i]; sin_valid = 1;
      out_ready = (i == int'(W) - 1);
      step();
    end
    sin_valid = 0; out_ready = 0;
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0110) begin errors++; $display("FAIL drain_load got=%b/%b exp=0110/1", out_data, out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL drain_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_async_reset();
    out_ready = 0;
    send_frame(4'b1111, -1, 0);
    start = 1; step(); start = 0;
    sin = 1; sin_valid = 1; step(); step(); sin_valid = 0;
    #2 reset = 0; m_reset();
    #1;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || overrun !== 1'b0 || out_data !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b valid=%b over=%b data=%b exp=0/0/0/0000", busy, out_valid, overrun, out_data);
    end
    @(posedge clk); #1; reset = 1;
    send_frame(4'b0101, -1, 0);
    checks++; if (out_valid !== 1'b1 || out_data !== 4'b0101) begin errors++; $display("FAIL async_reset_frame got=%b/%b exp=0101/1", out_data, out_valid); end
    out_ready = 1; step(); out_ready = 0;
  endtask

  task automatic test_random();
    int unsigned bad = 0;
    for (int c = 0; c < 1500; c++) begin
      start       = ($urandom_range(0, 15) == 0);
      sin_valid   = $urandom_range(0, 1);
      sin         = $urandom_range(0, 1);
      out_ready   = ($urandom_range(0, 2) == 0);
      clr_overrun = ($urandom_range(0, 7) == 0);
      step();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || busy !== m_busy || overrun !== m_over) begin
        errors++;
        if (bad < 10) $display("FAIL random_cycle%0d got v=%b d=%b b=%b o=%b exp v=%b d=%b b=%b o=%b",
                               c, out_valid, out_data, busy, overrun, m_valid, m_data, m_busy, m_over);
        bad++;
      end
    end
    idle_inputs(); out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gapped();
    test_restart();
    test_overrun();
    test_same_cycle_drain();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
